ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter.sv | 138 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between a CPU and a JTAG bridge, one access per three cycles.
// Define RAM_ARB_ROUND_ROBIN_EN to alternate grants on simultaneous requests; otherwise the CPU always wins.
//
// state  | meaning
// IDLE   | sample requests, latch the winner's command
// ACCESS | single RAM strobe driven from the latched command
// DONE   | read data returned and ack pulsed to the owner
module ram_port_arbiter #(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic          cpu_ack_o,
    output logic [DW-1:0] cpu_rdata_o,
    input  logic          jtag_req_i,
    input  logic          jtag_we_i,
    input  logic [AW-1:0] jtag_addr_i,
    input  logic [DW-1:0] jtag_wdata_i,
    output logic          jtag_ack_o,
    output logic [DW-1:0] jtag_rdata_o,
    output logic          ram_en_o,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_wdata_o,
    input  logic [DW-1:0] ram_rdata_i
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
    localparam bit RR_ENABLE = 1'b1;
`else
    localparam bit RR_ENABLE = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q;        // 0 = CPU, 1 = JTAG
    logic          we_q;
    logic          last_owner_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] jtag_rdata_q;
    logic          grant_valid;
    logic          grant_owner;

    // With fairness off the tie always resolves to the CPU; last_owner is then only bookkeeping.
    always_comb begin
        grant_valid = cpu_req_i | jtag_req_i;
        if (cpu_req_i && jtag_req_i) begin
            grant_owner = RR_ENABLE & ~last_owner_q;
        end else begin
            grant_owner = ~cpu_req_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ram_en_o   = 1'b0;
        ram_we_o   = 1'b0;
        cpu_ack_o  = 1'b0;
        jtag_ack_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                ram_en_o = 1'b1;
                ram_we_o = we_q;
                state_d  = S_DONE;
            end
            S_DONE: begin
                cpu_ack_o  = ~owner_q;
                jtag_ack_o = owner_q;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            last_owner_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else if (state_q == S_IDLE && grant_valid) begin
            owner_q      <= grant_owner;
            last_owner_q <= grant_owner;
            we_q         <= grant_owner ? jtag_we_i    : cpu_we_i;
            addr_q       <= grant_owner ? jtag_addr_i  : cpu_addr_i;
            wdata_q      <= grant_owner ? jtag_wdata_i : cpu_wdata_i;
        end
    end

    // RAM data arrives during DONE, so the owner sees it straight through while the register catches it.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cpu_rdata_q  <= '0;
            jtag_rdata_q <= '0;
        end else begin
            if (cpu_ack_o && !we_q) begin
                cpu_rdata_q <= ram_rdata_i;
            end
            if (jtag_ack_o && !we_q) begin
                jtag_rdata_q <= ram_rdata_i;
            end
        end
    end

    assign cpu_rdata_o  = (cpu_ack_o && !we_q)  ? ram_rdata_i : cpu_rdata_q;
    assign jtag_rdata_o = (jtag_ack_o && !we_q) ? ram_rdata_i : jtag_rdata_q;
    assign ram_addr_o   = addr_q;
    assign ram_wdata_o  = wdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed vector table, corner-case sequences and
// randomized traffic checked against a transaction-timing reference model with its own RAM image.
module tb_ram_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          cpu_req_i, cpu_we_i, jtag_req_i, jtag_we_i;
    logic [AW-1:0] cpu_addr_i, jtag_addr_i;
    logic [DW-1:0] cpu_wdata_i, jtag_wdata_i;
    logic          cpu_ack_o, jtag_ack_o, ram_en_o, ram_we_o;
    logic [DW-1:0] cpu_rdata_o, jtag_rdata_o, ram_wdata_o, ram_rdata_i;
    logic [AW-1:0] ram_addr_o;

    always #5 clk_i = ~clk_i;

    ram_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_ack_o(cpu_ack_o), .cpu_rdata_o(cpu_rdata_o),
        .jtag_req_i(jtag_req_i), .jtag_we_i(jtag_we_i), .jtag_addr_i(jtag_addr_i),
        .jtag_wdata_i(jtag_wdata_i), .jtag_ack_o(jtag_ack_o), .jtag_rdata_o(jtag_rdata_o),
        .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
    );

    // Unwritten locations read back as a pattern derived from the address.
    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {8'hA5, a, a};
    endfunction

    // Synchronous RAM: read data valid the cycle after the strobe.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    bit            written [0:(1<<AW)-1];
    always @(posedge clk_i) begin
        if (ram_en_o) begin
            if (ram_we_o) begin
                mem[ram_addr_o]     <= ram_wdata_o;
                written[ram_addr_o] <= 1'b1;
            end else begin
                ram_rdata_i <= written[ram_addr_o] ? mem[ram_addr_o] : pat(ram_addr_o);
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a grant at edge g puts the strobe in the cycle after g, the ack in the
    // cycle after g+1, and requests are looked at again from edge g+3 onwards.
    logic [DW-1:0] ref_mem [int];
    int            edge_k = 0;
    int            next_sample = 0;
    int            g = -100;
    bit            m_own, m_we, m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rd [2];

    function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return pat(a);
    endfunction

    task automatic model_reset();
        next_sample = edge_k + 1;
        g       = -100;
        m_last  = 1'b1;
        m_own   = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_rd[0] = '0;
        m_rd[1] = '0;
    endtask

    task automatic model_edge();
        edge_k++;
        if (edge_k == g + 1 && m_we) ref_mem[int'(m_addr)] = m_wdata;
        if (edge_k == g + 2 && !m_we) m_rd[m_own] = rd_val(m_addr);
        if (edge_k >= next_sample && (cpu_req_i || jtag_req_i)) begin
            if (cpu_req_i && jtag_req_i) m_own = RR ? !m_last : 1'b0;
            else                         m_own = jtag_req_i;
            m_we        = m_own ? jtag_we_i    : cpu_we_i;
            m_addr      = m_own ? jtag_addr_i  : cpu_addr_i;
            m_wdata     = m_own ? jtag_wdata_i : cpu_wdata_i;
            m_last      = m_own;
            g           = edge_k;
            next_sample = edge_k + 3;
        end
    endtask

    task automatic check_cycle();
        bit en, ack;
        en  = (edge_k == g);
        ack = (edge_k == g + 1);
        chk("ram_en", ram_en_o, en);
        chk("ram_we", ram_we_o, en & m_we);
        chk("ram_addr", ram_addr_o, m_addr);
        chk("ram_wdata", ram_wdata_o, m_wdata);
        chk("cpu_ack", cpu_ack_o, ack && !m_own);
        chk("jtag_ack", jtag_ack_o, ack && m_own);
        chk("cpu_rdata", cpu_rdata_o, (ack && !m_we && !m_own) ? rd_val(m_addr) : m_rd[0]);
        chk("jtag_rdata", jtag_rdata_o, (ack && !m_we && m_own) ? rd_val(m_addr) : m_rd[1]);
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        check_cycle();
    endtask

    task automatic rand_cpu();
        cpu_req_i   = 1'b1;
        cpu_we_i    = 1'($urandom_range(0, 1));
        cpu_addr_i  = AW'($urandom_range(0, 31));
        cpu_wdata_i = $urandom;
    endtask

    task automatic rand_jtag();
        jtag_req_i   = 1'b1;
        jtag_we_i    = 1'($urandom_range(0, 1));
        jtag_addr_i  = AW'($urandom_range(0, 31));
        jtag_wdata_i = $urandom;
    endtask

    typedef struct {
        logic c_req; logic c_we; logic [AW-1:0] c_addr; logic [DW-1:0] c_wdata;
        logic j_req; logic j_we; logic [AW-1:0] j_addr; logic [DW-1:0] j_wdata;
        logic e_own; logic e_we; logic [AW-1:0] e_addr; logic [DW-1:0] e_wdata; logic [DW-1:0] e_rd;
    } vec_t;

    vec_t vt [8];
    bit   obs [$];
    int   found;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vt[0] = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b1, 1'b1, 12'h3FF, 32'h12345678, 1'b1, 1'b1, 12'h3FF, 32'h12345678, 32'h0};
        vt[1] = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 32'h0};
        vt[2] = '{1'b1, 1'b0, 12'h010, 32'h0,        1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 1'b0, 12'h010, 32'h0,        32'hDEADBEEF};
        vt[3] = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b1, 1'b0, 12'h3FF, 32'h0,        1'b1, 1'b0, 12'h3FF, 32'h0,        32'h12345678};
        vt[4] = '{1'b1, 1'b1, 12'h020, 32'hCAFEF00D, 1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 1'b1, 12'h020, 32'hCAFEF00D, 32'hDEADBEEF};
        vt[5] = '{1'b1, 1'b0, 12'h005, 32'h0,        1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 1'b0, 12'h005, 32'h0,        32'hA5005005};
        vt[6] = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b1, 1'b0, 12'h020, 32'h0,        1'b1, 1'b0, 12'h020, 32'h0,        32'hCAFEF00D};
        vt[7] = '{1'b1, 1'b0, 12'h3FF, 32'h0,        1'b1, 1'b0, 12'h010, 32'h0,        1'b0, 1'b0, 12'h3FF, 32'h0,        32'h12345678};

        rstn_i = 1'b1;
        cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = '0; cpu_wdata_i = '0;
        jtag_req_i = 0; jtag_we_i = 0; jtag_addr_i = '0; jtag_wdata_i = '0;
        #2 rstn_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        check_cycle();
        chk("reset_ram_en", ram_en_o, 0);
        chk("reset_cpu_rdata", cpu_rdata_o, 0);

        // Both requesters held for six accesses straight out of reset.
        cpu_req_i = 1; cpu_addr_i = 12'h00A;
        jtag_req_i = 1; jtag_addr_i = 12'h00B;
        rstn_i = 1'b1;
        obs.delete();
        for (int s = 0; s < 18; s++) begin
            step();
            if (s == 0) chk("first_edge_grant", ram_en_o, 1);
            if (cpu_ack_o) obs.push_back(1'b0);
            if (jtag_ack_o) obs.push_back(1'b1);
        end
        cpu_req_i = 0; jtag_req_i = 0;
        step();
        chk("arb_grant_count", obs.size(), 6);
        for (int i = 0; i < 6 && i < obs.size(); i++) begin
            bit exp_o;
            exp_o = RR ? i[0] : 1'b0;
            chk("arb_grant_order", obs[i], exp_o);
        end

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            cpu_req_i = vt[i].c_req;  cpu_we_i = vt[i].c_we;  cpu_addr_i = vt[i].c_addr;  cpu_wdata_i = vt[i].c_wdata;
            jtag_req_i = vt[i].j_req; jtag_we_i = vt[i].j_we; jtag_addr_i = vt[i].j_addr; jtag_wdata_i = vt[i].j_wdata;
            step();
            chk("vec_en", ram_en_o, 1);
            chk("vec_we", ram_we_o, vt[i].e_we);
            chk("vec_addr", ram_addr_o, vt[i].e_addr);
            chk("vec_wdata", ram_wdata_o, vt[i].e_wdata);
            chk("vec_early_ack", cpu_ack_o | jtag_ack_o, 0);
            cpu_addr_i = ~cpu_addr_i;   cpu_wdata_i = ~cpu_wdata_i;   cpu_we_i = ~cpu_we_i;
            jtag_addr_i = ~jtag_addr_i; jtag_wdata_i = ~jtag_wdata_i; jtag_we_i = ~jtag_we_i;
            step();
            chk("vec_cpu_ack", cpu_ack_o, !vt[i].e_own);
            chk("vec_jtag_ack", jtag_ack_o, vt[i].e_own);
            chk("vec_rdata", vt[i].e_own ? jtag_rdata_o : cpu_rdata_o, vt[i].e_rd);
            cpu_req_i = 0; jtag_req_i = 0;
            step();
            chk("vec_idle_en", ram_en_o, 0);
        end

        // Address change after latch must not reach the RAM.
        cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 12'h001;
        step();
        cpu_addr_i = 12'h002;
        #1 chk("latched_addr_access", ram_addr_o, 12'h001);
        step();
        chk("latched_addr_done", ram_addr_o, 12'h001);
        chk("latched_rdata", cpu_rdata_o, 32'hA5001001);
        cpu_req_i = 0;
        step();

        // JTAG request arriving during a CPU access waits its turn.
        cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 12'h003;
        step();
        jtag_req_i = 1; jtag_we_i = 0; jtag_addr_i = 12'h004;
        found = -1;
        for (int n = 1; n <= 10 && found < 0; n++) begin
            step();
            if (cpu_ack_o) cpu_req_i = 0;
            if (ram_en_o && ram_addr_o == 12'h004) found = n;
        end
        chk("jtag_wait_cycles", found, 3);
        step();
        chk("jtag_wait_ack", jtag_ack_o, 1);
        jtag_req_i = 0;
        step();

        // Reset during ACCESS aborts the write without an ack.
        cpu_req_i = 1; cpu_we_i = 1; cpu_addr_i = 12'h055; cpu_wdata_i = 32'h11112222;
        step();
        chk("abort_pre_en", ram_en_o, 1);
        rstn_i = 1'b0;
        #1;
        chk("abort_en", ram_en_o, 0);
        chk("abort_ack", cpu_ack_o | jtag_ack_o, 0);
        model_reset();
        check_cycle();
        cpu_req_i = 0;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk_i);
            chk("abort_no_ack", cpu_ack_o | jtag_ack_o, 0);
        end
        rstn_i = 1'b1;
        step();
        step();
        cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 12'h055;
        step();
        step();
        chk("abort_recover_ack", cpu_ack_o, 1);
        chk("abort_recover_rdata", cpu_rdata_o, 32'hA5055055);
        cpu_req_i = 0;
        step();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            step();
            if (cpu_ack_o) begin
                if ($urandom_range(0, 1) == 1) rand_cpu(); else cpu_req_i = 0;
            end else if (!cpu_req_i) begin
                if ($urandom_range(0, 2) == 0) rand_cpu();
            end else if (edge_k == g && !m_own) begin
                cpu_addr_i = AW'($urandom); cpu_wdata_i = $urandom; cpu_we_i = 1'($urandom_range(0, 1));
            end
            if (jtag_ack_o) begin
                if ($urandom_range(0, 1) == 1) rand_jtag(); else jtag_req_i = 0;
            end else if (!jtag_req_i) begin
                if ($urandom_range(0, 2) == 0) rand_jtag();
            end else if (edge_k == g && m_own) begin
                jtag_addr_i = AW'($urandom); jtag_wdata_i = $urandom; jtag_we_i = 1'($urandom_range(0, 1));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
